// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - multi-channel synchronised edge detector with pending flags and event counters
// Optional glitch filter compiled in with `define EDGE_FILTER_EN.
module edge_detect_multi #(
  parameter int   CHANNELS    = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter int   CNT_WIDTH   = 8,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           signal,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS-1:0]           low2HighSignal,
  output logic [CHANNELS-1:0]           high2LowSignal,
  output logic [CHANNELS-1:0]           edgePulse,
  output logic [CHANNELS-1:0]           pending,
  output logic                          anyPending,
  output logic [CHANNELS*CNT_WIDTH-1:0] eventCount
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   edge_q, edge_d;
    logic                   pend_q, pend_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sync_out;
    logic                   lvl_f;

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef EDGE_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          filt_q, filt_d;

    // Level is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (sync_out != filt_q) begin
        if (fcnt_q == FW'(FILTER_LEN - 1)) begin
          filt_d = sync_out;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        filt_q <= IDLE_LEVEL;
        fcnt_q <= '0;
      end else begin
        filt_q <= filt_d;
        fcnt_q <= fcnt_d;
      end
    end

    assign lvl_f = filt_q;
`else
    assign lvl_f = sync_out;
`endif

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], signal[i]};
      prev_d = lvl_f;
      rise_d = lvl_f & ~prev_q;
      fall_d = ~lvl_f & prev_q;
      edge_d = (rise_d & mode[2*i]) | (fall_d & mode[2*i+1]);
      // A new event wins over a coincident clear so nothing is lost.
      pend_d = edge_d | (pend_q & ~clear[i]);
      cnt_d  = cnt_q;
      if (clear[i]) begin
        cnt_d    = '0;
        cnt_d[0] = edge_d;
      end else if (edge_d && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        prev_q <= IDLE_LEVEL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        edge_q <= 1'b0;
        pend_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        sync_q <= sync_d;
        prev_q <= prev_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        edge_q <= edge_d;
        pend_q <= pend_d;
        cnt_q  <= cnt_d;
      end
    end

    assign low2HighSignal[i]                     = rise_q;
    assign high2LowSignal[i]                     = fall_q;
    assign edgePulse[i]                          = edge_q;
    assign pending[i]                            = pend_q;
    assign eventCount[i*CNT_WIDTH +: CNT_WIDTH]  = cnt_q;
  end

  assign anyPending = |pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb/tb_edge_detect_multi.sv - self-checking bench for edge_detect_multi against a sample-history reference model
module tb_edge_detect_multi;
  localparam int   CH   = 4;
  localparam int   SYNC = 2;
  localparam int   FILT = 4;
  localparam int   CW   = 4;
  localparam logic IDLE = 1'b1;
  localparam int   MAXC = (1 << CW) - 1;
`ifdef EDGE_FILTER_EN
  localparam int   LAT  = SYNC + FILT;
  localparam bit   FON  = 1'b1;
`else
  localparam int   LAT  = SYNC;
  localparam bit   FON  = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     signal;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     clear;
  logic [CH-1:0]     low2HighSignal, high2LowSignal, edgePulse, pending;
  logic              anyPending;
  logic [CH*CW-1:0]  eventCount;

  int tests = 0;
  int fails = 0;

  edge_detect_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .CNT_WIDTH(CW), .IDLE_LEVEL(IDLE)
  ) dut (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .clear(clear),
    .low2HighSignal(low2HighSignal), .high2LowSignal(high2LowSignal),
    .edgePulse(edgePulse), .pending(pending), .anyPending(anyPending),
    .eventCount(eventCount)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled inputs, accepted level, expected outputs.
  bit mq [CH][$];
  bit mw [CH][$];
  bit mf [CH];
  bit mp [CH];
  bit erise [CH];
  bit efall [CH];
  bit eedge [CH];
  bit epend [CH];
  int ecnt  [CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      for (int k = 0; k < SYNC; k++) mq[c].push_back(IDLE);
      mw[c].delete();
      mf[c] = IDLE; mp[c] = IDLE;
      erise[c] = 0; efall[c] = 0; eedge[c] = 0; epend[c] = 0; ecnt[c] = 0;
    end
  endtask

  task automatic model_step();
    bit sb, fb, alldiff;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      sb = mq[c][0];
      fb = FON ? mf[c] : sb;
      erise[c] = fb & ~mp[c];
      efall[c] = ~fb & mp[c];
      mp[c] = fb;
      if (FON) begin
        mw[c].push_back(sb);
        if (mw[c].size() > FILT) void'(mw[c].pop_front());
        if (mw[c].size() == FILT) begin
          alldiff = 1'b1;
          foreach (mw[c][k]) if (mw[c][k] == mf[c]) alldiff = 1'b0;
          if (alldiff) begin
            mf[c] = sb;
            mw[c].delete();
          end
        end
      end
      void'(mq[c].pop_front());
      mq[c].push_back(signal[c]);
      eedge[c] = (erise[c] && mode[2*c]) || (efall[c] && mode[2*c+1]);
      epend[c] = eedge[c] || (epend[c] && !clear[c]);
      if (clear[c]) ecnt[c] = eedge[c] ? 1 : 0;
      else if (eedge[c] && ecnt[c] < MAXC) ecnt[c]++;
    end
  endtask

  task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  task automatic check_all();
    bit anyp;
    anyp = 0;
    for (int c = 0; c < CH; c++) begin
      chk("rise",    c, 32'(low2HighSignal[c]),      32'(erise[c]));
      chk("fall",    c, 32'(high2LowSignal[c]),      32'(efall[c]));
      chk("edge",    c, 32'(edgePulse[c]),           32'(eedge[c]));
      chk("pending", c, 32'(pending[c]),             32'(epend[c]));
      chk("count",   c, 32'(eventCount[c*CW +: CW]), 32'(ecnt[c]));
      anyp |= epend[c];
    end
    chk("anyPending", 0, 32'(anyPending), 32'(anyp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    int n, npulse;
    bit found;
    reset  = 1'b0;
    signal = '1;
    mode   = '1;
    clear  = '0;
    model_reset();
    @(negedge clk);
    #1 check_all();
    repeat (10) tick();
    reset = 1'b1;

    repeat (1000) tick();

    // Fall on ch0: latency and single count.
    signal[0] = 1'b0;
    n = 0; found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      tick();
      if (high2LowSignal[0]) begin n = k; found = 1; end
    end
    chk("lat_ch0", 0, 32'(n), 32'(LAT + 1));
    repeat (5) tick();
    chk("cnt_ch0", 0, 32'(eventCount[0 +: CW]), 32'd1);
    chk("pend_ch0", 0, 32'(pending[0]), 32'd1);

    // Ch1 short and long low pulses.
    signal[1] = 1'b0; repeat (3) tick();
    signal[1] = 1'b1; repeat (15) tick();
    chk("glitch3_cnt", 1, 32'(eventCount[CW +: CW]), FON ? 32'd0 : 32'd2);
    signal[1] = 1'b0; repeat (5) tick();
    signal[1] = 1'b1; repeat (15) tick();
    chk("pulse5_cnt", 1, 32'(eventCount[CW +: CW]), FON ? 32'd2 : 32'd4);

    // Ch2 rise-only, then off.
    mode[5:4] = 2'b01;
    signal[2] = 1'b0; repeat (12) tick();
    signal[2] = 1'b1; repeat (12) tick();
    signal[2] = 1'b0; repeat (12) tick();
    chk("rise_only_cnt", 2, 32'(eventCount[2*CW +: CW]), 32'd1);
    mode[5:4] = 2'b00;
    signal[2] = 1'b1;
    npulse = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (low2HighSignal[2]) npulse++;
    end
    chk("off_rise_seen", 2, 32'(npulse), 32'd1);
    chk("off_cnt", 2, 32'(eventCount[2*CW +: CW]), 32'd1);

    // Ch3 clear coincident with the event, then saturation.
    signal[3] = 1'b0;
    repeat (LAT) tick();
    clear[3] = 1'b1;
    tick();
    clear[3] = 1'b0;
    chk("clr_evt_pend", 3, 32'(pending[3]), 32'd1);
    chk("clr_evt_cnt", 3, 32'(eventCount[3*CW +: CW]), 32'd1);
    for (int e = 0; e < 20; e++) begin
      signal[3] = ~signal[3];
      repeat (LAT + 2) tick();
    end
    chk("sat_cnt", 3, 32'(eventCount[3*CW +: CW]), 32'(MAXC));
    clear[3] = 1'b1;
    tick();
    clear[3] = 1'b0;
    chk("clr_cnt", 3, 32'(eventCount[3*CW +: CW]), 32'd0);
    chk("clr_pend", 3, 32'(pending[3]), 32'd0);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(3) == 0) signal[c] = ~signal[c];
      if ($urandom_range(15) == 0) mode = 8'($urandom);
      clear = ($urandom_range(7) == 0) ? 4'($urandom) : 4'd0;
      tick();
    end
    clear = '0;

    // Reset while a fall is in flight.
    signal = '1; mode = '1;
    repeat (20) tick();
    signal[0] = 1'b0;
    repeat (LAT - 1) tick();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_rise",  0, 32'(low2HighSignal), 32'd0);
    chk("rst_fall",  0, 32'(high2LowSignal), 32'd0);
    chk("rst_edge",  0, 32'(edgePulse),      32'd0);
    chk("rst_pend",  0, 32'(pending),        32'd0);
    chk("rst_any",   0, 32'(anyPending),     32'd0);
    chk("rst_count", 0, 32'(eventCount),     32'd0);
    @(negedge clk);
    repeat (5) tick();
    reset = 1'b1;
    npulse = 0; n = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (high2LowSignal[0]) begin npulse++; n = k; end
    end
    chk("post_rst_pulses", 0, 32'(npulse), 32'd1);
    chk("post_rst_lat", 0, 32'(n), 32'(LAT + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel edge detector for the serial-port datapath, replacing the single-channel low-to-high detector. Each channel synchronises an asynchronous input, optionally glitch-filters it, and produces registered one-cycle rise/fall pulses, a mode-qualified event pulse, a sticky pending flag with clear handshake, and a saturating event counter. Typical use: start-bit (falling-edge) detection on RX lines and handshake-line monitoring.

## Interface
- CHANNELS, 4: number of independent input channels (1..16)
- SYNC_STAGES, 2: synchroniser flops per channel (>=2)
- FILTER_LEN, 4: consecutive stable synchronised samples required to accept a level change (>=1; used only with filter compiled in)
- CNT_WIDTH, 8: per-channel event counter width
- IDLE_LEVEL, 1: reset value of synchroniser and filtered level (line idle level)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- signal  in  CHANNELS  asynchronous channel inputs
- mode  in  2*CHANNELS  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clear  in  CHANNELS  per-channel one-cycle clear of pending and counter
- low2HighSignal  out  CHANNELS  one-cycle rising-edge pulse (not mode-gated)
- high2LowSignal  out  CHANNELS  one-cycle falling-edge pulse (not mode-gated)
- edgePulse  out  CHANNELS  one-cycle pulse for edges selected by mode
- pending  out  CHANNELS  sticky event flag
- anyPending  out  1  OR of pending
- eventCount  out  CHANNELS*CNT_WIDTH  channel i at [i*CNT_WIDTH +: CNT_WIDTH]

## Operation
- Per channel: sync chain -> filtered level f -> previous level p -> pulses.
- Filter: counter runs while sync output != f; resets to 0 when equal; f takes sync output once it has differed for FILTER_LEN consecutive cycles, counter then clears.
- low2HighSignal = f & ~p, high2LowSignal = ~f & p, registered.
- edgePulse: rise pulse if mode bit0, fall pulse if mode bit1; mode 00 suppresses edgePulse, pending set and counting.
- pending[i]: set by edgePulse[i], cleared by clear[i]; simultaneous set and clear -> remains set (no lost event).
- eventCount[i]: +1 per edgePulse[i], saturates at 2^CNT_WIDTH-1; clear[i] -> 0; simultaneous clear and event -> 1.
- mode changes take effect for edges detected in the next cycle; no pulse generated by a mode change itself.
- Channels fully independent; no arbitration.

## Timing
- Reset (asynchronous, reset=0): sync flops, f, p = IDLE_LEVEL; filter counters 0; all pulses 0; pending 0; anyPending 0; eventCount 0.
- Input change set up before clock edge E: pulse visible after edge E+SYNC_STAGES (filter out) or E+SYNC_STAGES+FILTER_LEN (filter in), high exactly one cycle.
- Input at non-idle level at reset release: one edge pulse after the above latency (e.g. IDLE_LEVEL=1, input 0 -> high2LowSignal).
- Glitch shorter than FILTER_LEN cycles at sync output: no pulse, f unchanged.
- Edges closer together than the latency: each accepted level change yields its own pulse; minimum pulse spacing 1 cycle (filter out) / FILTER_LEN cycles (filter in).
- pending/eventCount update on the same edge edgePulse becomes visible; anyPending combinational from pending.
- Reset asserted mid-operation: all state returns to reset values immediately, in-flight edges discarded.

## Configuration
- EDGE_FILTER_EN defined: glitch filter and FILTER_LEN counters present, latency SYNC_STAGES+FILTER_LEN.
- EDGE_FILTER_EN undefined: f = sync output, no filter logic, FILTER_LEN ignored, latency SYNC_STAGES.

## Test plan
- Reset 100 ns, CHANNELS=4, inputs idle high, mode=11 all: no pulses, eventCount all 0 for 1000 cycles.
- Ch0 1->0 at E, held: high2LowSignal[0] one cycle after E+2 (filter out) / E+6 (filter in); pending[0]=1, eventCount[0]=1.
- Filter in, ch1 low pulse of 3 cycles: no pulse; 5 cycles: fall then rise pulses, eventCount[1]=2.
- Ch2 mode=01, toggle 0->1->0: edgePulse only on rise, eventCount[2]=1; mode=00: no edgePulse, low2HighSignal still pulses.
- clear[3] same cycle as edgePulse[3]: pending[3] stays 1, eventCount[3]=1; CNT_WIDTH=4, 20 edges -> eventCount=15.
- Reset asserted mid-filter with input low: outputs zero at once; after release, input still low -> single high2LowSignal after full latency.
